// File: rtl/swap_monitor.sv
// swap_monitor
//   Watches the two outputs of an upstream swap stage and checks that they
//   exchange values on every clock. After LOCK_LEN consecutive swap events
//   the monitor locks; while locked it counts swaps, and a missing swap
//   drops lock through a one-cycle ERR state.
//
// Parameters
//   LOCK_LEN  consecutive swap events needed to lock (2..15)
//   CNT_W     width of swap_cnt_o / err_cnt_o
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   a_i, b_i    upstream swap-stage outputs
//   clr_i       synchronous clear of FSM and counters (history kept)
//   locked_o    high while in LOCK
//   err_o       one-cycle pulse on loss of lock
//   swap_cnt_o  swaps counted while locked, saturating
//   err_cnt_o   loss-of-lock count, saturating
//
// Build option
//   SWAP_MONITOR_ERRCNT_EN  when defined, err_cnt_o counts LOCK->ERR
//                           transitions; otherwise it is tied to 0.
//
// state | meaning
// HUNT  | looking for LOCK_LEN consecutive swap events
// LOCK  | swaps seen every cycle, swap_cnt_o counting
// ERR   | one-cycle loss-of-lock pulse, then back to HUNT
module swap_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] swap_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [3:0] RUN_LAST = 4'(LOCK_LEN - 1);

  state_t           state;
  logic             a_q, b_q, a_p, b_p;
  logic [1:0]       hist;
  logic [3:0]       run;
  logic [CNT_W-1:0] swap_cnt;
  logic             hist_v;
  logic             swap_ev;

  // Two samples are needed before a swap can be judged.
  assign hist_v  = (hist == 2'd2);
  assign swap_ev = hist_v & (a_q == b_p) & (b_q == a_p) & (a_q != b_q);

  // Sample pipeline and history are not affected by clr_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= 1'b0;
      b_q  <= 1'b0;
      a_p  <= 1'b0;
      b_p  <= 1'b0;
      hist <= 2'd0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      a_p <= a_q;
      b_p <= b_q;
      if (hist != 2'd2) hist <= hist + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      run      <= 4'd0;
      swap_cnt <= '0;
    end else if (clr_i) begin
      state    <= HUNT;
      run      <= 4'd0;
      swap_cnt <= '0;
    end else begin
      case (state)
        HUNT: begin
          if (swap_ev) begin
            if (run == RUN_LAST) begin
              state <= LOCK;
              run   <= 4'd0;
            end else begin
              run <= run + 4'd1;
            end
          end else begin
            run <= 4'd0;
          end
        end
        LOCK: begin
          if (swap_ev) begin
            if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
          end else begin
            state <= ERR;
          end
        end
        default: begin
          // ERR ignores swap events and always returns to a fresh hunt.
          state <= HUNT;
          run   <= 4'd0;
        end
      endcase
    end
  end

`ifdef SWAP_MONITOR_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_i) begin
      err_cnt <= '0;
    end else if (state == LOCK && !swap_ev && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  // Decoded straight from the state register: no input-to-output path,
  // and an async reset drops locked_o without passing through ERR.
  assign locked_o   = (state == LOCK);
  assign err_o      = (state == ERR);
  assign swap_cnt_o = swap_cnt;

endmodule
